// File: rtl/mode_control_pio.sv
// mode_control_pio: Avalon-MM output PIO with atomic set/clear and auto-clearing timed pulses
// Ports: clk, reset_n (async, active-low); address/chipselect/write_n/writedata slave write side;
// readdata combinational read mux; out_port registered control lines; pulse_busy high while a pulse times.
module mode_control_pio #(
  parameter int WIDTH = 1,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int CNT_W = 16,
  parameter logic [31:0] PULSE_RESET = 32'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);
  logic [WIDTH-1:0] data_out, pulse_mask, wd, d_exp, m_exp, d_nxt, m_nxt;
  logic [CNT_W-1:0] pulse_len, counter, eff_len, c_dec, c_nxt, len_nxt;
  logic wr, expire, w_data, w_len, w_set, w_clr, w_pulse;
  logic unused_wd;
  assign unused_wd = ^writedata;
  assign wd = writedata[WIDTH-1:0];
  assign out_port = data_out;
  // Expiry is resolved first, then any write of the same cycle is layered on top of it.
  always_comb begin
    wr = chipselect & ~write_n;
    w_data = wr & (address == 3'd0);
    w_len = wr & (address == 3'd1);
    w_set = wr & (address == 3'd4);
    w_clr = wr & (address == 3'd5);
    w_pulse = wr & (address == 3'd6);
    expire = counter == CNT_W'(1);
    eff_len = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    d_exp = expire ? data_out & ~pulse_mask : data_out;
    m_exp = expire ? '0 : pulse_mask;
    c_dec = (counter != '0) ? counter - CNT_W'(1) : '0;
    d_nxt = w_data ? wd : (w_set | w_pulse) ? d_exp | wd : w_clr ? d_exp & ~wd : d_exp;
    m_nxt = w_data ? '0 : (w_set | w_clr) ? m_exp & ~wd : w_pulse ? m_exp | wd : m_exp;
    c_nxt = w_data ? '0 : w_pulse ? eff_len : c_dec;
    len_nxt = w_len ? writedata[CNT_W-1:0] : pulse_len;
  end
  always_comb begin
    readdata = (address == 3'd0) ? 32'(data_out) :
               (address == 3'd1) ? 32'(pulse_len) :
               (address == 3'd7) ? (32'(pulse_mask) | {pulse_busy, 31'b0}) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      pulse_mask <= '0;
      pulse_len <= PULSE_RESET[CNT_W-1:0];
      counter <= '0;
      pulse_busy <= 1'b0;
    end else begin
      data_out <= d_nxt;
      pulse_mask <= m_nxt;
      pulse_len <= len_nxt;
      counter <= c_nxt;
      pulse_busy <= c_nxt != '0;
    end
  end
endmodule

// File: tb/tb_mode_control_pio.sv
// tb_mode_control_pio: randomized self-checking bench against an absolute-deadline reference model
module tb_mode_control_pio;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0] out_port;
  logic pulse_busy;
  int checks = 0;
  int errors = 0;
  logic [3:0] m_data, m_mask;
  logic [15:0] m_len;
  int m_dead, cyc;

  mode_control_pio #(.WIDTH(4), .RESET_VALUE(32'hA), .CNT_W(16), .PULSE_RESET(32'd1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 4'hA; m_mask = '0; m_len = 16'd1; m_dead = 0; cyc = 0;
  endtask

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0: mread = {28'd0, m_data};
      3'd1: mread = {16'd0, m_len};
      3'd7: mread = {m_dead > cyc, 27'd0, m_mask};
      default: mread = '0;
    endcase
  endfunction

  // One clock edge of the reference: deadlines are absolute cycle numbers.
  task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
    logic [3:0] w;
    w = d[3:0];
    cyc++;
    if (m_dead == cyc) begin
      m_data &= ~m_mask;
      m_mask = '0;
    end
    if (cs && !wn) begin
      case (a)
        3'd0: begin m_data = w; m_mask = '0; m_dead = 0; end
        3'd1: m_len = d[15:0];
        3'd4: begin m_data |= w; m_mask &= ~w; end
        3'd5: begin m_data &= ~w; m_mask &= ~w; end
        3'd6: begin m_data |= w; m_mask |= w; m_dead = cyc + ((m_len == 0) ? 1 : int'(m_len)); end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
    address = a; chipselect = cs; write_n = wn; writedata = d;
    #1;
    chk("readdata", readdata, mread(a));
    @(posedge clk);
    model_edge(a, cs, wn, d);
    #1;
    chk("out_port", {28'd0, out_port}, {28'd0, m_data});
    chk("pulse_busy", {31'd0, pulse_busy}, {31'd0, m_dead > cyc});
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(a, 1'b1, 1'b0, d);
  endtask

  task automatic idle(input logic [2:0] a);
    step(a, 1'b1, 1'b1, 32'hFFFF_FFFF);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", {28'd0, out_port}, 32'hA);
    chk("rst_busy", {31'd0, pulse_busy}, 32'd0);
    address = 3'd7; #1; chk("rst_status", readdata, 32'd0);
    address = 3'd1; #1; chk("rst_len", readdata, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wr(0, 32'hFFFF_FFF5);
    chk("data_5", {28'd0, out_port}, 32'h5);
    wr(4, 32'h2);
    chk("set_2", {28'd0, out_port}, 32'h7);
    wr(5, 32'h4);
    chk("clr_4", {28'd0, out_port}, 32'h3);
    idle(0);
    address = 3'd0; #1; chk("rd_data", readdata, 32'h3);
    address = 3'd2; #1; chk("rd_resv", readdata, 32'h0);
    address = 3'd4; #1; chk("rd_set", readdata, 32'h0);
    step(0, 1'b0, 1'b0, 32'hC);
    step(0, 1'b1, 1'b1, 32'hC);
    wr(1, 3); wr(0, 1); wr(6, 8);
    chk("p3_on", {28'd0, out_port}, 32'h9);
    address = 3'd7; #1; chk("p3_status", readdata, 32'h8000_0008);
    idle(7); idle(7);
    chk("p3_still", {28'd0, out_port}, 32'h9);
    idle(7);
    chk("p3_off", {28'd0, out_port}, 32'h1);
    address = 3'd7; #1; chk("p3_status_off", readdata, 32'h0);
    wr(0, 0); wr(1, 0); wr(6, 1);
    chk("p0_on", {28'd0, out_port}, 32'h1);
    idle(7);
    chk("p0_off", {28'd0, out_port}, 32'h0);
    wr(1, 5); wr(6, 1); idle(7); wr(6, 2);
    for (int i = 0; i < 4; i++) idle(7);
    chk("p5_both", {28'd0, out_port}, 32'h3);
    idle(7);
    chk("p5_clear", {28'd0, out_port}, 32'h0);
    wr(1, 4); wr(6, 3); wr(4, 1); idle(7); idle(7); idle(7);
    chk("set_keep", {28'd0, out_port}, 32'h1);
    wr(0, 0); wr(6, 3); wr(4, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_out", {28'd0, out_port}, 32'hA);
    chk("rst_mid_busy", {31'd0, pulse_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = (d & 32'hFFFF_0000) | $urandom_range(0, 6);
      step(a, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 0, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
